gtp_rx: RTL
===========

# gtp_rx

Receive-side framer for the Aurora/GTP user link. Consumes the 32-bit AXI-Stream RX beats produced by the Aurora core and parses the frame format the link transmitter emits: head, GTX ID, length/address word, data, CRC-32, end. Data words go to a dual-port packet RAM; the frame is reported good only after the CRC and end marker check. Sits between the Aurora RX user interface and the packet RAM / control logic in the `log_clk` domain.

## Interface
Parameters:
- `HEAD_WORD`, 32'h0000FFBC, start-of-frame marker
- `END_WORD`, 32'h0000FFBD, end-of-frame marker
- `CRC_INIT`, 32'hFFFFFFFF, CRC seed

Ports:
- `log_clk`  in  1  clock
- `log_rst_q`  in  1  reset, asynchronous, active-high
- `m_axi_rx_tdata`  in  32  RX beat data
- `m_axi_rx_tvalid`  in  1  beat valid; no backpressure, every valid beat is consumed
- `m_axi_rx_tlast`  in  1  last beat of frame
- `rx_ram_addr`  out  8  packet RAM write address
- `rx_ram_data`  out  32  packet RAM write data
- `rx_ram_wren`  out  1  packet RAM write enable
- `rx_packet_gtxid`  out  32  GTX ID of last good frame
- `rx_packet_head`  out  32  length/address word of last good frame
- `rx_packet_done`  out  1  one-cycle pulse: good frame received
- `rx_crc_err`  out  1  one-cycle pulse: CRC mismatch
- `rx_frame_err`  out  1  one-cycle pulse: framing error
- `rx_crc_calc`  out  32  running CRC register (debug)

## Operation
- Frame: HEAD_WORD, GTXID, LEN, N data words, CRC, END_WORD with tlast. LEN[7:0] = N (0..255), LEN[15:8] = RAM start address S, LEN[31:16] ignored.
- States: IDLE, GTXID, LENGTH, DATA, CHECK, END, DROP. All transitions only on a valid beat.
- IDLE: beat == HEAD_WORD and !tlast -> GTXID; else stay IDLE (non-head beats silently discarded).
- GTXID: latch shadow GTXID -> LENGTH. LENGTH: latch shadow LEN, load word counter with N, address pointer with S -> DATA if N != 0 else CHECK.
- DATA: write beat to RAM at pointer, pointer +1 mod 256 (wraps 8'hFF -> 8'h00), counter -1; counter reaching 0 -> CHECK.
- CHECK: compare beat with CRC register -> END; mismatch recorded.
- END: beat == END_WORD and tlast and CRC matched -> done pulse, shadows copied to `rx_packet_gtxid`/`rx_packet_head`, IDLE. CRC mismatch (END valid) -> `rx_crc_err`, IDLE. Wrong END word -> `rx_frame_err`; to IDLE if tlast else DROP.
- tlast on any beat in GTXID/LENGTH/DATA/CHECK -> `rx_frame_err`, IDLE. DROP: discard until tlast beat, then IDLE.
- CRC: CRC-32 poly 0x04C11DB7, 32-bit parallel update identical to the link TX equation, no reflection, no final XOR. Reset to CRC_INIT in IDLE; updated on valid beats in GTXID, LENGTH, DATA only.
- RAM contents written before an error are not rolled back; consumers use RAM only after `rx_packet_done`.

## Timing
- Reset values: all outputs 0, except `rx_crc_calc` = 32'hFFFFFFFF; state IDLE.
- RAM write registered: `rx_ram_wren`/addr/data valid the cycle after the DATA beat; single-cycle wren per word.
- `rx_packet_done`, `rx_crc_err`, `rx_frame_err` assert the cycle after the END (or offending) beat, one cycle wide, mutually exclusive.
- `rx_packet_gtxid`/`rx_packet_head` update same edge as `rx_packet_done`; hold until next good frame.
- Back-to-back frames: HEAD beat immediately after END beat is accepted (zero gap).
- tvalid gaps anywhere: state, counter, CRC hold.
- Reset mid-frame: immediate IDLE, pending pulses cleared, no RAM write.

## Structure
- Package `gtp_pkg`: HEAD/END word constants, state encoding, `nextCRC32_D32` function shared with the TX framer.
- One natural sub-module: `crc32_d32` (registered CRC with init/enable), reusable on TX side.

## Test plan
- Good frame, GTXID 0x00000005, LEN 0x00000304, data 1..4 -> writes at 0x03..0x06, `rx_packet_done` once, head reads 0x00000304.
- Same frame with CRC word bit 0 flipped -> 4 RAM writes, `rx_crc_err` once, no done, gtxid/head outputs unchanged.
- LEN 0x0000FE03 -> writes at 0xFE, 0xFF, 0x00; done asserted.
- tlast on second data beat -> `rx_frame_err`, IDLE; next good frame accepted.
- Garbage beats 0x12345678, then two back-to-back good frames with random tvalid gaps -> garbage ignored, two done pulses, correct RAM data.
- Reset asserted during DATA -> outputs to reset values, no further wren, subsequent frame received correctly.

Source files
------------

// File: rtl/gtp_pkg.sv
// gtp_pkg: shared framing constants, receive state encoding and the parallel CRC-32 step.
package gtp_pkg;
  localparam logic [31:0] HEAD_WORD_C = 32'h0000FFBC;
  localparam logic [31:0] END_WORD_C  = 32'h0000FFBD;
  localparam logic [31:0] CRC_INIT_C  = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_POLY_C  = 32'h04C11DB7;

  typedef enum logic [2:0] {
    S_IDLE, S_GTXID, S_LENGTH, S_DATA, S_CHECK, S_END, S_DROP
  } rx_state_t;

  // Data word enters MSB first, no reflection; matches the TX framer equation.
  function automatic logic [31:0] nextCRC32_D32(input logic [31:0] data, input logic [31:0] crc);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--)
      c = {c[30:0], 1'b0} ^ ((c[31] ^ data[i]) ? CRC_POLY_C : 32'h0);
    return c;
  endfunction
endpackage

// File: rtl/crc32_d32.sv
// crc32_d32: registered CRC-32 over 32-bit words with synchronous re-seed and enable.
module crc32_d32 import gtp_pkg::*; #(
  parameter logic [31:0] INIT = CRC_INIT_C
) (
  input  logic        log_clk,
  input  logic        log_rst_q,
  input  logic        init,
  input  logic        en,
  input  logic [31:0] data,
  output logic [31:0] crc
);
  always_ff @(posedge log_clk or posedge log_rst_q)
    if (log_rst_q) crc <= INIT;
    else if (init) crc <= INIT;
    else if (en) crc <= nextCRC32_D32(data, crc);
endmodule

// File: rtl/gtp_rx.sv
// gtp_rx: Aurora RX framer; parses head/gtxid/len/data/crc/end beats, writes data to packet RAM.
module gtp_rx import gtp_pkg::*; #(
  parameter logic [31:0] HEAD_WORD = HEAD_WORD_C,
  parameter logic [31:0] END_WORD  = END_WORD_C,
  parameter logic [31:0] CRC_INIT  = CRC_INIT_C
) (
  input  logic        log_clk,
  input  logic        log_rst_q,
  input  logic [31:0] m_axi_rx_tdata,
  input  logic        m_axi_rx_tvalid,
  input  logic        m_axi_rx_tlast,
  output logic [7:0]  rx_ram_addr,
  output logic [31:0] rx_ram_data,
  output logic        rx_ram_wren,
  output logic [31:0] rx_packet_gtxid,
  output logic [31:0] rx_packet_head,
  output logic        rx_packet_done,
  output logic        rx_crc_err,
  output logic        rx_frame_err,
  output logic [31:0] rx_crc_calc
);
  rx_state_t   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, ptr_q, ptr_d;
  logic [31:0] gtxid_q, gtxid_d, len_q, len_d, td;
  logic        crc_ok_q, crc_ok_d, wr_d, done_d, crc_err_d, frame_err_d, crc_en, tl;

  assign td = m_axi_rx_tdata;
  assign tl = m_axi_rx_tlast;

  crc32_d32 #(.INIT(CRC_INIT)) u_crc (
    .log_clk   (log_clk),
    .log_rst_q (log_rst_q),
    .init      (state_q == S_IDLE),
    .en        (crc_en),
    .data      (td),
    .crc       (rx_crc_calc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    gtxid_d = gtxid_q;
    len_d = len_q;
    crc_ok_d = crc_ok_q;
    wr_d = 1'b0;
    done_d = 1'b0;
    crc_err_d = 1'b0;
    frame_err_d = 1'b0;
    crc_en = 1'b0;
    if (m_axi_rx_tvalid) begin
      if (state_q inside {S_GTXID, S_LENGTH, S_DATA, S_CHECK} && tl) begin
        frame_err_d = 1'b1;
        state_d = S_IDLE;
      end else
        case (state_q)
          S_IDLE:   if (td == HEAD_WORD && !tl) state_d = S_GTXID;
          S_GTXID: begin
            gtxid_d = td;
            crc_en = 1'b1;
            state_d = S_LENGTH;
          end
          S_LENGTH: begin
            len_d = td;
            cnt_d = td[7:0];
            ptr_d = td[15:8];
            crc_en = 1'b1;
            state_d = td[7:0] != 8'd0 ? S_DATA : S_CHECK;
          end
          S_DATA: begin
            wr_d = 1'b1;
            crc_en = 1'b1;
            ptr_d = ptr_q + 8'd1;
            cnt_d = cnt_q - 8'd1;
            state_d = cnt_q == 8'd1 ? S_CHECK : S_DATA;
          end
          S_CHECK: begin
            crc_ok_d = td == rx_crc_calc;
            state_d = S_END;
          end
          S_END: begin
            done_d = td == END_WORD && tl && crc_ok_q;
            crc_err_d = td == END_WORD && tl && !crc_ok_q;
            frame_err_d = !(td == END_WORD && tl);
            state_d = tl ? S_IDLE : S_DROP;
          end
          S_DROP:   if (tl) state_d = S_IDLE;
          default:  state_d = S_IDLE;
        endcase
    end
  end

  always_ff @(posedge log_clk or posedge log_rst_q)
    if (log_rst_q) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      ptr_q <= '0;
      gtxid_q <= '0;
      len_q <= '0;
      crc_ok_q <= 1'b0;
      rx_ram_addr <= '0;
      rx_ram_data <= '0;
      rx_ram_wren <= 1'b0;
      rx_packet_gtxid <= '0;
      rx_packet_head <= '0;
      rx_packet_done <= 1'b0;
      rx_crc_err <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      gtxid_q <= gtxid_d;
      len_q <= len_d;
      crc_ok_q <= crc_ok_d;
      rx_ram_wren <= wr_d;
      rx_packet_done <= done_d;
      rx_crc_err <= crc_err_d;
      rx_frame_err <= frame_err_d;
      if (wr_d) begin
        rx_ram_addr <= ptr_q;
        rx_ram_data <= td;
      end
      if (done_d) begin
        rx_packet_gtxid <= gtxid_q;
        rx_packet_head <= len_q;
      end
    end
endmodule
